bitlet_align_scheduler: RTL and testbench
=========================================

Name: bitlet_align_scheduler

Overview:
- Two-pass sequencer in front of a `Bitlet_AlignerArray` instance. The block instantiates the array internally.
- Pass 1 (collect): accepts a group of up to DEPTH beats. Each beat carries N_align (Wabs, Esum) lane pairs. Beats are buffered and a running maximum of Esum (Emax) is tracked.
- Pass 2 (drain): replays the buffered beats through the aligner array using the final group Emax. The aligned weights are presented to the downstream adder tree over a valid/ready stream.

Parameters:
- N_align, 8, lanes per beat; passed to the aligner array.
- DEPTH, 4, maximum beats per group (buffer entries); must be ≥ 2.
- PTR_W, $clog2(DEPTH), pointer width; local, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  marks the final beat of a group.
- in_wabs_vec  in  N_align*`Wid_abs  lane weight magnitudes.
- in_esum_vec  in  N_align*`Wid_exs  lane exponent sums, unsigned.
- out_valid  out  1  aligned beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of the group.
- out_walign_vec  out  N_align*`Wid_abs  aligned magnitudes.
- out_emax  out  `Wid_exs  group Emax; constant for the whole drain.
- busy  out  1  high when a group is partially collected or draining.

Behaviour:
- States are COLLECT (reset state) and DRAIN.
- Reset values:
  - state = COLLECT
  - wr_ptr = 0, rd_ptr = 0
  - emax_r = 0, close_r = 0
  - out_valid = 0, out_last = 0, busy = 0
  - in_ready = 1 one cycle after deassertion; it is combinational from state.
  - Buffer contents are don't-care.
- Reset mid-operation: any partially collected or partially drained group is discarded. No output beat is produced for it.

COLLECT state:
- in_ready = 1 and out_valid = 0.
- A beat is accepted when in_valid && in_ready:
  - the lanes are written to buf[wr_ptr];
  - emax_r <= max(emax_r, max over lanes of Esum), using an unsigned comparison;
  - wr_ptr is incremented.
- The group closes on an accepted beat when in_last = 1 or wr_ptr == DEPTH-1 (buffer full). A full-buffer close forces group termination even without in_last.
- On close: the next state is DRAIN, rd_ptr = 0, and n_beats = wr_ptr+1 is latched.

DRAIN state:
- in_ready = 0 and out_valid = 1.
- The block presents:
  - out_walign_vec = AlignerArray(buf[rd_ptr] Wabs, buf[rd_ptr] Esum, emax_r). This is combinational from registers: data is valid in the same cycle as out_valid.
  - out_emax = emax_r.
  - out_last = (rd_ptr == n_beats-1).
- Handshake:
  - On out_valid && out_ready, rd_ptr is incremented.
  - On the last beat's handshake: state returns to COLLECT, wr_ptr = 0 and emax_r = 0.
- If out_ready = 0, all outputs hold stable (no data change while valid and not ready).

Timing and throughput:
- Latency: the first output beat is valid the cycle after the closing input beat is accepted.
- Throughput: one beat per cycle in each pass. There is no overlap between groups; in_ready stays 0 through the whole DRAIN.

Other rules:
- busy = (state == DRAIN) || (wr_ptr != 0).
- Arithmetic: Ediff = emax_r - Esum is always ≥ 0 by construction. A shift ≥ `Wid_abs yields 0.
- in_last on a non-accepted cycle is ignored.

Optional Feature:
- Macro: BITLET_ALIGN_ZERO_MASK_EN.
- Defined: lanes with Wabs == 0 are excluded from the Emax update. A beat with all lanes zero leaves emax_r unchanged, and an all-zero group yields out_emax = 0.
- Undefined: all lanes participate in the Emax update regardless of Wabs.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, busy=0, out_emax=0.
- 2-beat group, Esum beat0 lanes {3,5,...}, beat1 max 7, in_last on beat1 → next cycle out_valid=1, out_emax=7; a lane with Wabs=0x80 and Esum=5 outputs 0x20; out_last on the 2nd output beat only.
- 4 beats with no in_last (DEPTH=4) → forced close after beat 3; 4 output beats; out_last on the 4th.
- out_ready low for 3 cycles mid-drain → outputs held constant; no beat lost or duplicated; in_ready stays 0.
- rst asserted during DRAIN at rd_ptr=1 → immediate return to COLLECT; out_valid=0; the next group's Emax is unaffected by the old group.
- Lane with Wabs=0 and Esum=15, others Esum ≤ 4 → out_emax=4 with BITLET_ALIGN_ZERO_MASK_EN defined, 15 without.

Source files
------------

// File: rtl/bitlet_align_scheduler.sv
// Two-pass group sequencer: collect up to DEPTH beats while tracking Emax, then replay them through the aligner array.
// Optional macro BITLET_ALIGN_ZERO_MASK_EN: lanes with zero magnitude are kept out of the Emax update.
`ifndef Wid_abs
`define Wid_abs 8
`endif
`ifndef Wid_exs
`define Wid_exs 6
`endif

module Bitlet_AlignerArray #(
  parameter int N_align = 8
) (
  input  logic [N_align*`Wid_abs-1:0] wabs_vec,
  input  logic [N_align*`Wid_exs-1:0] esum_vec,
  input  logic [`Wid_exs-1:0]         emax,
  output logic [N_align*`Wid_abs-1:0] walign_vec
);
  localparam int WA = `Wid_abs;
  localparam int WE = `Wid_exs;

  for (genvar i = 0; i < N_align; i++) begin : g_lane
    logic [WE-1:0] ediff;
    assign ediff = emax - esum_vec[i*WE +: WE];
    // Shifting the whole magnitude out leaves nothing; make that explicit.
    assign walign_vec[i*WA +: WA] = (ediff >= WE'(WA)) ? '0 : (wabs_vec[i*WA +: WA] >> ediff);
  end
endmodule

// state   | meaning
// COLLECT | accepting beats into the buffer, tracking running Emax
// DRAIN   | replaying buffered beats aligned to the final group Emax
module bitlet_align_scheduler #(
  parameter int N_align = 8,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [N_align*`Wid_abs-1:0] in_wabs_vec,
  input  logic [N_align*`Wid_exs-1:0] in_esum_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [N_align*`Wid_abs-1:0] out_walign_vec,
  output logic [`Wid_exs-1:0]         out_emax,
  output logic                        busy
);
  localparam int WA    = `Wid_abs;
  localparam int WE    = `Wid_exs;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {COLLECT, DRAIN} state_t;

  state_t state_r, state_nx;

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, last_ptr;
  logic [WE-1:0]         emax_r, beat_max;
  logic [N_align-1:0]    lane_en;
  logic                  accept, close, pop, pop_last;
  logic [N_align*WA-1:0] wabs_mem [DEPTH];
  logic [N_align*WE-1:0] esum_mem [DEPTH];

  for (genvar i = 0; i < N_align; i++) begin : g_en
`ifdef BITLET_ALIGN_ZERO_MASK_EN
    assign lane_en[i] = |in_wabs_vec[i*WA +: WA];
`else
    assign lane_en[i] = 1'b1;
`endif
  end

  always_comb begin
    beat_max = '0;
    for (int i = 0; i < N_align; i++) begin
      if (lane_en[i] && (in_esum_vec[i*WE +: WE] > beat_max))
        beat_max = in_esum_vec[i*WE +: WE];
    end
  end

  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (wr_ptr == PTR_W'(DEPTH-1)));
  assign pop      = out_valid && out_ready;
  assign pop_last = pop && out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= COLLECT;
    else     state_r <= state_nx;
  end

  always_comb begin
    state_nx  = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_r)
      COLLECT: begin
        in_ready = 1'b1;
        if (close) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_ptr == last_ptr);
        if (out_ready && out_last) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_ptr <= '0;
      emax_r   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        emax_r <= (beat_max > emax_r) ? beat_max : emax_r;
      end
      if (close) begin
        rd_ptr   <= '0;
        last_ptr <= wr_ptr;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop_last) begin
        wr_ptr <= '0;
        emax_r <= '0;
      end
    end
  end

  // Buffer contents need no reset; they are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      wabs_mem[wr_ptr] <= in_wabs_vec;
      esum_mem[wr_ptr] <= in_esum_vec;
    end
  end

  Bitlet_AlignerArray #(.N_align(N_align)) u_align (
    .wabs_vec   (wabs_mem[rd_ptr]),
    .esum_vec   (esum_mem[rd_ptr]),
    .emax       (emax_r),
    .walign_vec (out_walign_vec)
  );

  assign out_emax = emax_r;
  assign busy     = (state_r == DRAIN) || (wr_ptr != '0);
endmodule

// File: tb/tb_bitlet_align_scheduler.sv
// Scoreboard bench for bitlet_align_scheduler: group model pushes expected beats, negedge monitor pops and compares.
`ifndef Wid_abs
`define Wid_abs 8
`endif
`ifndef Wid_exs
`define Wid_exs 6
`endif

module tb_bitlet_align_scheduler;
  localparam int NA    = 8;
  localparam int DEPTH = 4;
  localparam int WA    = `Wid_abs;
  localparam int WE    = `Wid_exs;

  logic            clk, rst;
  logic            in_valid, in_ready, in_last;
  logic [NA*WA-1:0] in_wabs_vec;
  logic [NA*WE-1:0] in_esum_vec;
  logic            out_valid, out_ready, out_last, busy;
  logic [NA*WA-1:0] out_walign_vec;
  logic [WE-1:0]   out_emax;

  bitlet_align_scheduler #(.N_align(NA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_wabs_vec(in_wabs_vec), .in_esum_vec(in_esum_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_walign_vec(out_walign_vec), .out_emax(out_emax), .busy(busy)
  );

  typedef struct packed {
    logic [NA*WA-1:0] w;
    logic [WE-1:0]    em;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [NA*WA-1:0] m_w [DEPTH];
  logic [NA*WE-1:0] m_e [DEPTH];
  logic [WE-1:0]    m_emax;
  int               m_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NA*WA-1:0] f_align(input logic [NA*WA-1:0] w,
                                              input logic [NA*WE-1:0] e,
                                              input logic [WE-1:0] em);
    logic [NA*WA-1:0] r;
    int sh;
    r = '0;
    for (int i = 0; i < NA; i++) begin
      sh = int'(em) - int'(e[i*WE +: WE]);
      r[i*WA +: WA] = (sh >= WA) ? '0 : (w[i*WA +: WA] >> sh);
    end
    return r;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input logic [NA*WA-1:0] w, input logic [NA*WE-1:0] e, input logic last);
    int guard;
    exp_t x;
    in_valid = 1'b1; in_wabs_vec = w; in_esum_vec = e; in_last = last;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        check_val("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    sync();
    in_valid = 1'b0; in_last = 1'b0;
    m_w[m_n] = w; m_e[m_n] = e;
    for (int i = 0; i < NA; i++) begin
`ifdef BITLET_ALIGN_ZERO_MASK_EN
      if (w[i*WA +: WA] != '0)
`endif
        if (e[i*WE +: WE] > m_emax) m_emax = e[i*WE +: WE];
    end
    m_n++;
    if (last || m_n == DEPTH) begin
      for (int b = 0; b < m_n; b++) begin
        x.w = f_align(m_w[b], m_e[b], m_emax);
        x.em = m_emax;
        x.last = (b == m_n - 1);
        sb.push_back(x);
      end
      m_n = 0; m_emax = '0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        check_val("drain_timeout", 64'(sb.size()), 64'd0);
        break;
      end
    end
    sync();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_beat", 64'(out_valid), 64'd0);
      end else begin
        check_val("walign", 64'(out_walign_vec), 64'(sb[0].w));
        check_val("emax",   64'(out_emax),       64'(sb[0].em));
        check_val("last",   64'(out_last),       64'(sb[0].last));
        check_val("in_ready_drain", 64'(in_ready), 64'd0);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NA*WA-1:0] w;
    logic [NA*WE-1:0] e;
    int len;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_wabs_vec = '0; in_esum_vec = '0;
    m_n = 0; m_emax = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset / idle
    @(negedge clk);
    check_val("idle_in_ready",  64'(in_ready),  64'd1);
    check_val("idle_out_valid", 64'(out_valid), 64'd0);
    check_val("idle_busy",      64'(busy),      64'd0);
    check_val("idle_emax",      64'(out_emax),  64'd0);
    sync();

    // 2-beat group; lane1 of beat0: 0x80 at Esum 5 vs Emax 7 -> 0x20
    w = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h80, 8'h77};
    e = {6'd5, 6'd3, 6'd4, 6'd2, 6'd0, 6'd1, 6'd5, 6'd3};
    send_beat(w, e, 1'b0);
    check_val("busy_partial", 64'(busy), 64'd1);
    w = {8'hff, 8'h10, 8'h20, 8'h40, 8'h08, 8'h01, 8'h9c, 8'hc3};
    e = {6'd5, 6'd4, 6'd3, 6'd0, 6'd1, 6'd6, 6'd2, 6'd7};
    send_beat(w, e, 1'b1);
    @(negedge clk);
    check_val("latency_valid", 64'(out_valid), 64'd1);
    check_val("lane_0x20",     64'(out_walign_vec[15:8]), 64'h20);
    check_val("grp2_emax",     64'(out_emax), 64'd7);
    check_val("grp2_first_last", 64'(out_last), 64'd0);
    wait_drain();

    // forced close at DEPTH beats without in_last
    for (int b = 0; b < DEPTH; b++) begin
      w = {$urandom, $urandom};
      for (int i = 0; i < NA; i++) e[i*WE +: WE] = WE'($urandom_range(0, 12));
      send_beat(w, e, 1'b0);
    end
    @(negedge clk);
    check_val("forced_close_valid", 64'(out_valid), 64'd1);
    wait_drain();

    // backpressure: stall 3 cycles after first beat drains
    for (int b = 0; b < DEPTH; b++) begin
      w = {$urandom, $urandom};
      for (int i = 0; i < NA; i++) e[i*WE +: WE] = WE'($urandom_range(0, 10));
      send_beat(w, e, b == DEPTH - 1);
    end
    sync();
    out_ready = 1'b0;
    repeat (3) sync();
    check_val("stall_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // reset during drain at rd_ptr = 1
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      w = {$urandom, $urandom} | 64'h0101010101010101;
      e = {NA{6'd20}};
      send_beat(w, e, b == 2);
    end
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
    rst = 1'b1;
    sb.delete();
    m_n = 0; m_emax = '0;
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy",      64'(busy),      64'd0);
    sync();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
    sync();
    w = 64'h0102030405060708;
    e = {6'd3, 6'd1, 6'd2, 6'd0, 6'd3, 6'd2, 6'd1, 6'd0};
    send_beat(w, e, 1'b0);
    send_beat(~w, e, 1'b1);
    @(negedge clk);
    check_val("post_rst_emax", 64'(out_emax), 64'd3);
    wait_drain();

    // zero-magnitude lane with the largest Esum
    w = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'h00};
    e = {6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd4, 6'd2, 6'd15};
    send_beat(w, e, 1'b1);
    @(negedge clk);
`ifdef BITLET_ALIGN_ZERO_MASK_EN
    check_val("zero_lane_emax", 64'(out_emax), 64'd4);
`else
    check_val("zero_lane_emax", 64'(out_emax), 64'd15);
`endif
    wait_drain();

    // random groups, back to back
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(1, DEPTH);
      for (int b = 0; b < len; b++) begin
        w = {$urandom, $urandom};
        for (int i = 0; i < NA; i++) e[i*WE +: WE] = WE'($urandom_range(0, 20));
        send_beat(w, e, b == len - 1);
      end
    end
    wait_drain();
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    check_val("end_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
